// File: rtl/cu_vertex_job_dispatch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cu_vertex_job_dispatch_if                                                  |
// | Filtered-vertex input beat plus edge-job output bus of the push CU.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cu_vertex_job_dispatch_if #(
  parameter int VERTEX_SIZE_BITS = 32,
  parameter int EDGE_SIZE_BITS   = 32,
  parameter int COUNT_BITS       = 4
);
  logic                        vertex_in_valid;
  logic [VERTEX_SIZE_BITS-1:0] vertex_in_id;
  logic [EDGE_SIZE_BITS-1:0]   vertex_in_out_degree;
  logic [EDGE_SIZE_BITS-1:0]   vertex_in_edges_idx;
  logic                        vertex_request_filtered;

  logic                        edge_job_request;
  logic                        edge_job_valid;
  logic [VERTEX_SIZE_BITS-1:0] edge_job_vertex_id;
  logic [EDGE_SIZE_BITS-1:0]   edge_job_edge_idx;
  logic [COUNT_BITS-1:0]       edge_job_count;
  logic                        edge_job_last;

  // master: filter + edge fetch side; slave: the dispatcher
  modport master (
    output vertex_in_valid, vertex_in_id, vertex_in_out_degree, vertex_in_edges_idx,
    output edge_job_request,
    input  vertex_request_filtered,
    input  edge_job_valid, edge_job_vertex_id, edge_job_edge_idx, edge_job_count, edge_job_last
  );

  modport slave (
    input  vertex_in_valid, vertex_in_id, vertex_in_out_degree, vertex_in_edges_idx,
    input  edge_job_request,
    output vertex_request_filtered,
    output edge_job_valid, edge_job_vertex_id, edge_job_edge_idx, edge_job_count, edge_job_last
  );
endinterface
`default_nettype wire

// File: rtl/cu_vertex_job_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cu_vertex_job_dispatch                                                     |
// | Pulls filtered vertices into a skid FIFO and splits each out-degree into  |
// | edge jobs. Optional macro CU_EDGE_JOB_ALIGN_EN aligns chunks to           |
// | MAX_EDGE_CHUNK boundaries. Revision: 1.0                                   |
// +----------------------------------------------------------------------------+
module cu_vertex_job_dispatch #(
  parameter int VERTEX_SKID_DEPTH = 4,
  parameter int REQ_LATENCY       = 3,
  parameter int MAX_EDGE_CHUNK    = 8,
  parameter int VERTEX_SIZE_BITS  = 32,
  parameter int EDGE_SIZE_BITS    = 32
) (
  input  wire logic                        clock,
  input  wire logic                        rstn,
  input  wire logic                        enabled_in,
  input  wire logic [VERTEX_SIZE_BITS-1:0] vertex_total,
  cu_vertex_job_dispatch_if.slave          bus,
  output logic      [VERTEX_SIZE_BITS-1:0] vertex_job_counter_done,
  output logic      [EDGE_SIZE_BITS-1:0]   edge_job_counter,
  output logic                             done_out
);
  localparam int c_ptr_w   = $clog2(VERTEX_SKID_DEPTH);
  localparam int c_cnt_w   = c_ptr_w + 1;
  localparam int c_req_w   = c_cnt_w + 1;
  localparam int c_chunk_w = $clog2(MAX_EDGE_CHUNK) + 1;
  localparam logic [EDGE_SIZE_BITS-1:0] c_max_chunk = EDGE_SIZE_BITS'(MAX_EDGE_CHUNK);
  localparam logic [c_req_w-1:0]        c_req_limit = c_req_w'(VERTEX_SKID_DEPTH - REQ_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SPLIT = 2'd2
  } state_t;

  state_t                      r_state;
  logic                        r_enabled;
  logic                        r_request;
  logic                        r_zero_drop;
  logic [VERTEX_SIZE_BITS-1:0] r_skid_id  [VERTEX_SKID_DEPTH];
  logic [EDGE_SIZE_BITS-1:0]   r_skid_deg [VERTEX_SKID_DEPTH];
  logic [EDGE_SIZE_BITS-1:0]   r_skid_idx [VERTEX_SKID_DEPTH];
  logic [c_ptr_w-1:0]          r_wr_ptr;
  logic [c_ptr_w-1:0]          r_rd_ptr;
  logic [c_cnt_w-1:0]          r_skid_count;
  logic [EDGE_SIZE_BITS-1:0]   r_remaining;
  logic                        r_job_valid;
  logic                        r_job_last;
  logic [VERTEX_SIZE_BITS-1:0] r_job_id;
  logic [EDGE_SIZE_BITS-1:0]   r_job_idx;
  logic [c_chunk_w-1:0]        r_job_count;
  logic [VERTEX_SIZE_BITS-1:0] r_done_count;
  logic [EDGE_SIZE_BITS-1:0]   r_job_counter;

  logic                        w_push;
  logic                        w_fire;
  logic                        w_last_fire;
  logic                        w_pop;
  logic [c_cnt_w-1:0]          w_count_next;
  logic [EDGE_SIZE_BITS-1:0]   w_job_count_ext;
  logic [EDGE_SIZE_BITS-1:0]   w_rem_after;
  logic [EDGE_SIZE_BITS-1:0]   w_idx_after;
  logic [EDGE_SIZE_BITS-1:0]   w_first_lim;

  function automatic logic [EDGE_SIZE_BITS-1:0] f_min(input logic [EDGE_SIZE_BITS-1:0] a,
                                                      input logic [EDGE_SIZE_BITS-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Zero-degree vertices never enter the FIFO; they are only counted.
  assign w_push          = bus.vertex_in_valid && (bus.vertex_in_out_degree != '0);
  assign w_fire          = r_job_valid && bus.edge_job_request;
  assign w_last_fire     = w_fire && r_job_last;
  assign w_pop           = r_enabled && (r_skid_count != '0) &&
                           ((r_state == ST_IDLE) || ((r_state == ST_SPLIT) && w_last_fire));
  assign w_count_next    = r_skid_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  assign w_job_count_ext = EDGE_SIZE_BITS'(r_job_count);
  assign w_rem_after     = r_remaining - w_job_count_ext;
  assign w_idx_after     = r_job_idx + w_job_count_ext;

`ifdef CU_EDGE_JOB_ALIGN_EN
  localparam int c_off_w = $clog2(MAX_EDGE_CHUNK);
  assign w_first_lim = c_max_chunk - EDGE_SIZE_BITS'(r_job_idx[c_off_w-1:0]);
`else
  assign w_first_lim = c_max_chunk;
`endif

  always_ff @(posedge clock) begin
    if (rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_skid_count <= '0;
    end else begin
      if (w_push) begin
        r_skid_id[r_wr_ptr]  <= bus.vertex_in_id;
        r_skid_deg[r_wr_ptr] <= bus.vertex_in_out_degree;
        r_skid_idx[r_wr_ptr] <= bus.vertex_in_edges_idx;
        r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_skid_count <= w_count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (rstn) begin
      r_state       <= ST_IDLE;
      r_enabled     <= 1'b0;
      r_request     <= 1'b0;
      r_zero_drop   <= 1'b0;
      r_remaining   <= '0;
      r_job_valid   <= 1'b0;
      r_job_last    <= 1'b0;
      r_job_id      <= '0;
      r_job_idx     <= '0;
      r_job_count   <= '0;
      r_done_count  <= '0;
      r_job_counter <= '0;
    end else begin
      r_enabled    <= enabled_in;
      // Looking at next-cycle occupancy keeps the request aligned with the count it guards.
      r_request    <= r_enabled && ({1'b0, w_count_next} < c_req_limit);
      r_zero_drop  <= bus.vertex_in_valid && (bus.vertex_in_out_degree == '0);
      r_done_count <= r_done_count + VERTEX_SIZE_BITS'(r_zero_drop) + VERTEX_SIZE_BITS'(w_last_fire);
      if (w_fire) begin
        r_job_counter <= r_job_counter + EDGE_SIZE_BITS'(1);
      end

      if (w_pop) begin
        r_job_id    <= r_skid_id[r_rd_ptr];
        r_job_idx   <= r_skid_idx[r_rd_ptr];
        r_remaining <= r_skid_deg[r_rd_ptr];
        r_job_valid <= 1'b0;
        r_state     <= ST_LOAD;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (r_enabled) begin
              r_job_count <= c_chunk_w'(f_min(r_remaining, w_first_lim));
              r_job_last  <= (r_remaining <= w_first_lim);
              r_job_valid <= enabled_in;
              r_state     <= ST_SPLIT;
            end
          end
          ST_SPLIT: begin
            if (w_last_fire) begin
              r_job_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              if (w_fire) begin
                r_job_idx   <= w_idx_after;
                r_remaining <= w_rem_after;
                r_job_count <= c_chunk_w'(f_min(w_rem_after, c_max_chunk));
                r_job_last  <= (w_rem_after <= c_max_chunk);
              end
              // Valid tracks the incoming enable so it never outlives r_enabled.
              r_job_valid <= enabled_in;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.vertex_request_filtered = r_request;
  assign bus.edge_job_valid          = r_job_valid;
  assign bus.edge_job_vertex_id      = r_job_id;
  assign bus.edge_job_edge_idx       = r_job_idx;
  assign bus.edge_job_count          = r_job_count;
  assign bus.edge_job_last           = r_job_last;
  assign vertex_job_counter_done     = r_done_count;
  assign edge_job_counter            = r_job_counter;
  assign done_out                    = r_enabled && (r_done_count == vertex_total);

endmodule
`default_nettype wire

// File: tb/tb_cu_vertex_job_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cu_vertex_job_dispatch                                                  |
// | Scoreboard bench: reference chunking model, filter model, job monitor.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cu_vertex_job_dispatch;
  localparam int VB   = 32;
  localparam int EB   = 32;
  localparam int MAXC = 8;
  localparam int CB   = $clog2(MAXC) + 1;
`ifdef CU_EDGE_JOB_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic [VB-1:0] id;
    logic [EB-1:0] idx;
    logic [CB-1:0] cnt;
    logic          last;
  } job_t;

  typedef struct packed {
    logic [VB-1:0] id;
    logic [EB-1:0] idx;
    logic [EB-1:0] deg;
  } vtx_t;

  logic          clock = 1'b0;
  logic          rstn = 1'b1;
  logic          enabled_in = 1'b0;
  logic [VB-1:0] vertex_total = '0;
  logic [VB-1:0] done_cnt;
  logic [EB-1:0] job_cnt;
  logic          done_out;

  cu_vertex_job_dispatch_if #(.VERTEX_SIZE_BITS(VB), .EDGE_SIZE_BITS(EB), .COUNT_BITS(CB)) bus ();

  cu_vertex_job_dispatch #(
    .VERTEX_SKID_DEPTH(4), .REQ_LATENCY(3), .MAX_EDGE_CHUNK(MAXC),
    .VERTEX_SIZE_BITS(VB), .EDGE_SIZE_BITS(EB)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .vertex_total(vertex_total),
    .bus(bus), .vertex_job_counter_done(done_cnt), .edge_job_counter(job_cnt), .done_out(done_out)
  );

  always #5 clock = ~clock;

  job_t exp_q[$];
  vtx_t filt_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   model_jobs = 0;
  int   model_vtx = 0;
  bit   filt_always = 1'b1;
  int   bp_mode = 0;
  int   bp_k = 0;
  logic req_seen = 1'b0;
  bit   hold_v = 1'b0;
  job_t held;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference chunking straight from the rules: min(remaining, limit), last when it covers the rest.
  task automatic send_vertex(input logic [VB-1:0] id, input logic [EB-1:0] idx, input int deg);
    vtx_t v;
    job_t j;
    int rem, lim, c;
    logic [EB-1:0] cur;
    bit first;
    v.id = id; v.idx = idx; v.deg = EB'(deg);
    filt_q.push_back(v);
    model_vtx++;
    rem = deg; cur = idx; first = 1'b1;
    while (rem > 0) begin
      lim = MAXC;
      if (ALIGN && first) lim = MAXC - int'(cur % MAXC);
      c = (rem < lim) ? rem : lim;
      j.id = id; j.idx = cur; j.cnt = CB'(c); j.last = (c == rem);
      exp_q.push_back(j);
      cur = cur + EB'(c);
      rem = rem - c;
      first = 1'b0;
      model_jobs++;
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) req_seen = bus.vertex_request_filtered;

  // Filter model: answers a request on the following cycle, sometimes with no data.
  always @(posedge clock) begin : p_filter
    vtx_t v;
    #1;
    if (!rstn && req_seen && filt_q.size() > 0 && (filt_always || $urandom_range(0, 3) != 0)) begin
      v = filt_q.pop_front();
      bus.vertex_in_valid      = 1'b1;
      bus.vertex_in_id         = v.id;
      bus.vertex_in_edges_idx  = v.idx;
      bus.vertex_in_out_degree = v.deg;
    end else begin
      bus.vertex_in_valid      = 1'b0;
      bus.vertex_in_id         = '0;
      bus.vertex_in_edges_idx  = '0;
      bus.vertex_in_out_degree = '0;
    end
  end

  always @(posedge clock) begin : p_backpressure
    #1;
    bp_k = bp_k + 1;
    case (bp_mode)
      0:       bus.edge_job_request = 1'b1;
      1:       bus.edge_job_request = ((bp_k % 4) == 0) || ((bp_k % 4) == 3);
      2:       bus.edge_job_request = 1'($urandom_range(0, 1));
      default: bus.edge_job_request = 1'b0;
    endcase
  end

  always @(negedge clock) begin : p_monitor
    job_t cur;
    if (rstn) begin
      hold_v = 1'b0;
    end else begin
      cur = '{bus.edge_job_vertex_id, bus.edge_job_edge_idx, bus.edge_job_count, bus.edge_job_last};
      if (hold_v)
        chk("stall_hold", 128'({bus.edge_job_valid, cur}), 128'({1'b1, held}));
      if (bus.edge_job_valid) begin
        if (bus.edge_job_request) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_job: got %0h expected none", cur);
          end else begin
            chk("edge_job", 128'(cur), 128'(exp_q.pop_front()));
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = cur;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [VB-1:0] total);
    enabled_in = 1'b0;
    rstn = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    filt_q.delete();
    model_jobs = 0;
    model_vtx = 0;
    vertex_total = total;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || filt_q.size() != 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (exp_q.size() != 0 || filt_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d jobs pending expected 0", name, exp_q.size());
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic check_counters(input string name);
    chk({name, "_jobs"}, 128'(job_cnt), 128'(model_jobs));
    chk({name, "_vertices"}, 128'(done_cnt), 128'(model_vtx));
    chk({name, "_done"}, 128'(done_out), 128'(1));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_req"}, 128'(bus.vertex_request_filtered), 128'(0));
    chk({name, "_valid"}, 128'(bus.edge_job_valid), 128'(0));
    chk({name, "_fields"}, 128'({bus.edge_job_vertex_id, bus.edge_job_edge_idx,
                                 bus.edge_job_count, bus.edge_job_last}), 128'(0));
    chk({name, "_vcnt"}, 128'(done_cnt), 128'(0));
    chk({name, "_jcnt"}, 128'(job_cnt), 128'(0));
    chk({name, "_done"}, 128'(done_out), 128'(0));
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    int c0, k, deg;
    int degs[6];
    degs = '{0, 3, 0, 0, 9, 1};

    // Reset state and idle enable behaviour
    do_reset('0);
    check_all_zero("reset");
    rstn = 1'b0;
    enabled_in = 1'b1;
    tick();
    chk("req_first_edge", 128'(bus.vertex_request_filtered), 128'(0));
    chk("done_total0", 128'(done_out), 128'(1));
    tick();
    chk("req_second_edge", 128'(bus.vertex_request_filtered), 128'(1));
    repeat (5) begin
      tick();
      chk("idle_req", 128'(bus.vertex_request_filtered), 128'(1));
      chk("idle_valid", 128'(bus.edge_job_valid), 128'(0));
    end

    // Single vertex, downstream always ready, with latency measurement
    do_reset(32'd1);
    rstn = 1'b0;
    enabled_in = 1'b1;
    bp_mode = 0;
    filt_always = 1'b1;
    send_vertex(32'd5, 32'd100, 20);
    k = 0;
    while (!bus.vertex_in_valid && k < 50) begin @(negedge clock); k++; end
    c0 = cyc;
    k = 0;
    while (!bus.edge_job_valid && k < 50) begin @(negedge clock); k++; end
    chk("first_job_latency", 128'(cyc - c0), 128'(3));
    wait_done(500, "single");
    check_counters("single");

    // Same vertex under 1,0,0,1 backpressure
    do_reset(32'd1);
    rstn = 1'b0;
    enabled_in = 1'b1;
    bp_mode = 1;
    send_vertex(32'd5, 32'd100, 20);
    wait_done(500, "backpressure");
    check_counters("backpressure");

    // Six-vertex stream with zero-degree vertices mixed in
    do_reset(32'd6);
    rstn = 1'b0;
    enabled_in = 1'b1;
    bp_mode = 2;
    filt_always = 1'b0;
    for (int i = 0; i < 6; i++) send_vertex(VB'(20 + i), EB'(32 * i), degs[i]);
    tick();
    tick();
    chk("stream_done_low", 128'(done_out), 128'(0));
    wait_done(2000, "stream");
    check_counters("stream");

    // Randomized vertices and backpressure
    do_reset(32'd40);
    rstn = 1'b0;
    enabled_in = 1'b1;
    bp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      deg = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      send_vertex(VB'($urandom), EB'($urandom_range(0, 1 << 20)), deg);
    end
    wait_done(10000, "random");
    check_counters("random");

    // Reset asserted while a vertex is being split
    do_reset(32'd1);
    rstn = 1'b0;
    enabled_in = 1'b1;
    bp_mode = 3;
    filt_always = 1'b1;
    send_vertex(32'd9, 32'd3, 40);
    k = 0;
    while (!bus.edge_job_valid && k < 50) begin @(negedge clock); k++; end
    chk("split_reached", 128'(bus.edge_job_valid), 128'(1));
    rstn = 1'b1;
    tick();
    check_all_zero("mid_reset");
    do_reset(32'd1);
    rstn = 1'b0;
    enabled_in = 1'b1;
    bp_mode = 2;
    send_vertex(32'd11, 32'd64, 13);
    wait_done(500, "after_reset");
    check_counters("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
